ngc_counter_bank: RTL

Parametrised bank of independent up/down counters sharing one clock and one programmable prescaler. Each channel supports wrap-reload, one-shot, cascade and free-running modes, with step values, registered hit flags, wrap pulses and sticky per-channel interrupt flags. It is the multi-channel successor to the single counter and serves as the timer/event-counting core for peripheral and sequencing logic.

---
 rtl/ngc_counter_bank.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ngc_counter_bank.sv
// ---------------------------------------------------------------------------
// ngc_counter_bank
//
// A bank of CHANNELS independent up/down counters. All channels share one
// clock and one programmable prescaler. Each channel runs in one of four modes:
//   00 wrap     : count by +/-step; on reaching to_value, reload from_value
//   01 one-shot : stop at to_value, raise done and emit a single wrap pulse
//   10 cascade  : like wrap, but advances on the lower channel's wrap event
//   11 free-run : modulo 2^WIDTH; carry/borrow is the wrap event
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   sync_clr        synchronous clear of every channel to from_value
//   prescale        shared tick period minus one
//   enb/dir/mode    per-channel enable, direction (1 = down), mode (2b each)
//   load/load_value per-channel synchronous load
//   from_value      reload/clear value per channel
//   to_value        terminal value per channel
//   step_value      increment magnitude per channel
//   irq_clr         clears the sticky irq flag
//   count           current counter values (registered)
//   hit             registered count == to_value
//   wrap            one-cycle pulse per terminal/reload event
//   done            one-shot completed, held until load/sync_clr
//   irq             sticky wrap flag
// ---------------------------------------------------------------------------
module ngc_counter_bank #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sync_clr,
    input  logic [PRESCALE_W-1:0]        prescale,
    input  logic [CHANNELS-1:0]          enb,
    input  logic [CHANNELS-1:0]          dir,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [CHANNELS-1:0]          load,
    input  logic [CHANNELS*WIDTH-1:0]    load_value,
    input  logic [CHANNELS*WIDTH-1:0]    from_value,
    input  logic [CHANNELS*WIDTH-1:0]    to_value,
    input  logic [CHANNELS*WIDTH-1:0]    step_value,
    input  logic [CHANNELS-1:0]          irq_clr,
    output logic [CHANNELS*WIDTH-1:0]    count,
    output logic [CHANNELS-1:0]          hit,
    output logic [CHANNELS-1:0]          wrap,
    output logic [CHANNELS-1:0]          done,
    output logic [CHANNELS-1:0]          irq
);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_CASCADE = 2'b10;
    localparam logic [1:0] MODE_FREERUN = 2'b11;

    logic [PRESCALE_W-1:0]     pre_cnt_q, pre_cnt_d;
    logic                      tick_s;
    logic [CHANNELS*WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0]       hit_q, hit_d;
    logic [CHANNELS-1:0]       wrap_q, wrap_d;
    logic [CHANNELS-1:0]       done_q, done_d;
    logic [CHANNELS-1:0]       irq_q, irq_d;

    // per-channel scratch values used inside the channel loop
    logic [WIDTH-1:0] cur_s, nxt_s, from_s, to_s, step_s, stepped_s;
    logic [WIDTH:0]   sum_s, diff_s;
    logic [1:0]       mode_s;
    logic             carry_s, term_s, adv_s, wrap_ev_s, casc_s;

    // Prescaler: a tick when pre_cnt matches prescale; an out-of-range
    // pre_cnt (prescale lowered below it) returns to 0 without a tick.
    always_comb begin
        tick_s = (pre_cnt_q == prescale);
        if (sync_clr) begin
            pre_cnt_d = '0;
        end else if (pre_cnt_q >= prescale) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
        end
    end

    // Channel next-state. Channels are evaluated in ascending order so that a
    // cascade channel sees the wrap event of the channel below it in the same
    // cycle; a chain of cascades therefore ripples combinationally.
    always_comb begin
        count_d   = count_q;
        done_d    = done_q;
        hit_d     = '0;
        wrap_d    = '0;
        irq_d     = '0;
        cur_s     = '0;
        nxt_s     = '0;
        from_s    = '0;
        to_s      = '0;
        step_s    = '0;
        stepped_s = '0;
        sum_s     = '0;
        diff_s    = '0;
        mode_s    = MODE_WRAP;
        carry_s   = 1'b0;
        term_s    = 1'b0;
        adv_s     = 1'b0;
        wrap_ev_s = 1'b0;
        casc_s    = tick_s;     // channel 0 in cascade mode follows the tick
        for (int i = 0; i < CHANNELS; i++) begin
            cur_s   = count_q[i*WIDTH +: WIDTH];
            from_s  = from_value[i*WIDTH +: WIDTH];
            to_s    = to_value[i*WIDTH +: WIDTH];
            step_s  = step_value[i*WIDTH +: WIDTH];
            mode_s  = mode[2*i +: 2];
            sum_s   = {1'b0, cur_s} + {1'b0, step_s};
            diff_s  = {1'b0, cur_s} - {1'b0, step_s};
            if (dir[i]) begin
                stepped_s = diff_s[WIDTH-1:0];
                carry_s   = diff_s[WIDTH];      // borrow
            end else begin
                stepped_s = sum_s[WIDTH-1:0];
                carry_s   = sum_s[WIDTH];       // carry out
            end
            term_s = (cur_s == to_s);
            if (mode_s == MODE_CASCADE) begin
                adv_s = enb[i] & casc_s;
            end else begin
                adv_s = enb[i] & tick_s;
            end
            wrap_ev_s = 1'b0;
            nxt_s     = cur_s;
            if (sync_clr) begin
                nxt_s     = from_s;
                done_d[i] = 1'b0;
            end else if (load[i]) begin
                nxt_s     = load_value[i*WIDTH +: WIDTH];
                done_d[i] = 1'b0;
            end else if (!adv_s) begin
                nxt_s = cur_s;
            end else if (mode_s == MODE_FREERUN) begin
                nxt_s     = stepped_s;
                wrap_ev_s = carry_s;
            end else if (term_s && (mode_s == MODE_ONESHOT)) begin
                // one-shot parks at the terminal value; only the first
                // arrival is an event
                nxt_s = cur_s;
                if (!done_q[i]) begin
                    done_d[i] = 1'b1;
                    wrap_ev_s = 1'b1;
                end else begin
                    done_d[i] = done_q[i];
                end
            end else if (term_s) begin
                nxt_s     = from_s;
                wrap_ev_s = 1'b1;
            end else begin
                // includes overshoot: a step past to_value just wraps modulo
                nxt_s = stepped_s;
            end
            count_d[i*WIDTH +: WIDTH] = nxt_s;
            hit_d[i]  = (nxt_s == to_s);
            wrap_d[i] = wrap_ev_s;
            irq_d[i]  = wrap_ev_s | (irq_q[i] & ~irq_clr[i]);   // set wins
            casc_s    = wrap_ev_s;
        end
    end

    // State registers with asynchronous reset of every output to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            count_q   <= '0;
            hit_q     <= '0;
            wrap_q    <= '0;
            done_q    <= '0;
            irq_q     <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            count_q   <= count_d;
            hit_q     <= hit_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            irq_q     <= irq_d;
        end
    end

    assign count = count_q;
    assign hit   = hit_q;
    assign wrap  = wrap_q;
    assign done  = done_q;
    assign irq   = irq_q;

endmodule
